// File: rtl/matrix_pkg.sv
// matrix_pkg: shared defaults, loader state encoding and the flat-bus
// element offset helper used by both the loader and the multiplier datapath.
package matrix_pkg;

    localparam int MAT_N  = 2;
    localparam int MAT_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        FULL
    } matload_state_t;

    // Bit offset of element (r,c) in a row-major flat matrix bus.
    function automatic int unsigned elem_offset(
        input int unsigned r,
        input int unsigned c,
        input int unsigned n,
        input int unsigned dw
    );
        return (r * n + c) * dw;
    endfunction

endpackage

// File: rtl/matrix_bank.sv
// matrix_bank: register bank holding operand matrices A and B (N*N elements
// each, row-major) with a single write port and flat read-out buses.
module matrix_bank
    import matrix_pkg::*;
#(
    parameter int N  = MAT_N,
    parameter int DW = MAT_DW,
    parameter int IW = $clog2(N*N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,   // 0 writes A, 1 writes B
    input  logic [IW-1:0]     wr_idx,
    input  logic [DW-1:0]     wr_data,
    output logic [N*N*DW-1:0] a_flat,
    output logic [N*N*DW-1:0] b_flat
);

    logic [DW-1:0] a_mem [N*N];
    logic [DW-1:0] b_mem [N*N];

    // Write the addressed element of A or B on each accepted element.
    // NOTE: the arrays are reset because the flat buses must read 0 after reset; this makes them flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N*N; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_sel) begin
                b_mem[wr_idx] <= wr_data;
            end else begin
                a_mem[wr_idx] <= wr_data;
            end
        end
    end

    // Pack both arrays onto the flat buses, element (r,c) at its row-major offset.
    always_comb begin
        a_flat = '0;
        b_flat = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_flat[elem_offset(r, c, N, DW) +: DW] = a_mem[r*N + c];
                b_flat[elem_offset(r, c, N, DW) +: DW] = b_mem[r*N + c];
            end
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: accepts a valid/ready element stream, fills matrices A then B,
// pulses start once both are complete and holds the bank until done rises.
// Optional feature: define MATLOAD_ABORT_EN to add an abort input that
// discards a partial load.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int N  = MAT_N,
    parameter int DW = MAT_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    output logic              in_ready,
    input  logic              done,
`ifdef MATLOAD_ABORT_EN
    input  logic              abort,
`endif
    output logic              start,
    output logic              loaded,
    output logic [N*N*DW-1:0] a_flat,
    output logic [N*N*DW-1:0] b_flat
);

    localparam int            IW   = $clog2(N*N);
    localparam logic [IW-1:0] LAST = IW'(N*N - 1);

    matload_state_t state, state_d;
    logic [IW-1:0]  idx, idx_d;
    logic           start_d, loaded_d;
    logic           done_q;
    logic           done_rise;
    logic           xfer;
    logic           abort_hit;
    logic           wr_en, wr_sel;

    assign in_ready  = (state != FULL);
    assign xfer      = in_valid && in_ready;
    assign done_rise = done && !done_q;

`ifdef MATLOAD_ABORT_EN
    assign abort_hit = abort && (state == LOAD_A || state == LOAD_B);
`else
    assign abort_hit = 1'b0;
`endif

    // State, counter, status flags and the done edge register.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            start  <= 1'b0;
            loaded <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            start  <= start_d;
            loaded <= loaded_d;
            done_q <= done;
        end
    end

    // Next-state, counter update and bank write control.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        start_d  = 1'b0;
        loaded_d = loaded;
        wr_en    = 1'b0;
        wr_sel   = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    wr_en   = 1'b1;
                    idx_d   = IW'(1);
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                if (abort_hit) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (xfer) begin
                    wr_en = 1'b1;
                    idx_d = (idx == LAST) ? '0 : idx + 1'b1;
                    if (idx == LAST) begin
                        state_d = LOAD_B;
                    end
                end
            end
            LOAD_B: begin
                if (abort_hit) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (xfer) begin
                    wr_en  = 1'b1;
                    wr_sel = 1'b1;
                    idx_d  = (idx == LAST) ? '0 : idx + 1'b1;
                    if (idx == LAST) begin
                        state_d  = FULL;
                        start_d  = 1'b1;
                        loaded_d = 1'b1;
                    end
                end
            end
            FULL: begin
                // Only a fresh 0->1 of done releases the bank; a sticky high level does not.
                if (done_rise) begin
                    state_d  = IDLE;
                    loaded_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    matrix_bank #(
        .N  (N),
        .DW (DW),
        .IW (IW)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_idx  (idx),
        .wr_data (in_data),
        .a_flat  (a_flat),
        .b_flat  (b_flat)
    );

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed sequence with randomized data and valid gaps,
// checked every cycle against a stream-position model of the loader.
`timescale 1ns/1ps
module tb_matrix_loader;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int NN = N*N;
    localparam int FW = NN*DW;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          done     = 1'b0;
    logic          in_ready;
    logic          start;
    logic          loaded;
    logic [FW-1:0] a_flat;
    logic [FW-1:0] b_flat;
`ifdef MATLOAD_ABORT_EN
    logic          abort    = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: elements counted by stream position within a load.
    logic [DW-1:0] mdl_a [NN];
    logic [DW-1:0] mdl_b [NN];
    int            mdl_count;
    bit            mdl_full;
    bit            mdl_start;
    bit            mdl_done_prev;

    always #5 clk = ~clk;

    matrix_loader #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .done     (done),
`ifdef MATLOAD_ABORT_EN
        .abort    (abort),
`endif
        .start    (start),
        .loaded   (loaded),
        .a_flat   (a_flat),
        .b_flat   (b_flat)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        logic [FW-1:0] ea;
        logic [FW-1:0] eb;
        for (int i = 0; i < NN; i++) begin
            ea[i*DW +: DW] = mdl_a[i];
            eb[i*DW +: DW] = mdl_b[i];
        end
        check({where, " start"},    start,    mdl_start);
        check({where, " loaded"},   loaded,   mdl_full);
        check({where, " in_ready"}, in_ready, !mdl_full);
        check({where, " a_flat"},   a_flat,   ea);
        check({where, " b_flat"},   b_flat,   eb);
    endtask

    task automatic model_accept(input logic [DW-1:0] d);
        if (mdl_count < NN) mdl_a[mdl_count] = d;
        else                mdl_b[mdl_count - NN] = d;
        mdl_count++;
        if (mdl_count == 2*NN) begin
            mdl_count = 0;
            mdl_full  = 1'b1;
            mdl_start = 1'b1;
        end
    endtask

    // One clock: capture the inputs seen at the edge, advance the model, check.
    task automatic step(input string where);
        bit            hs;
        bit            ab;
        logic [DW-1:0] d;
        bit            dn;
        hs = in_valid && !mdl_full;
        d  = in_data;
        dn = done;
        ab = 1'b0;
`ifdef MATLOAD_ABORT_EN
        ab = abort;
`endif
        @(posedge clk);
        #1;
        mdl_start = 1'b0;
        if (mdl_full) begin
            if (dn && !mdl_done_prev) mdl_full = 1'b0;
        end else if (ab && mdl_count != 0) begin
            mdl_count = 0;
        end else if (hs) begin
            model_accept(d);
        end
        mdl_done_prev = dn;
        check_all(where);
    endtask

    task automatic do_reset(input string where);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NN; i++) begin
            mdl_a[i] = '0;
            mdl_b[i] = '0;
        end
        mdl_count     = 0;
        mdl_full      = 1'b0;
        mdl_start     = 1'b0;
        mdl_done_prev = 1'b0;
        check_all(where);
        #2 rst_n = 1'b1;
    endtask

    // Feed elements until the model reports a full bank, with a cycle budget.
    task automatic load_stream(input bit gaps, input bit seq, input logic [DW-1:0] first);
        logic [DW-1:0] next_val;
        int            cyc;
        next_val = first;
        cyc      = 0;
        while (!mdl_full && cyc < 200) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = in_valid ? next_val : DW'($urandom);
            step("load");
            if (in_valid) next_val = seq ? next_val + 1'b1 : DW'($urandom);
            cyc++;
        end
        in_valid = 1'b0;
        check("load_complete", loaded, 1'b1);
    endtask

    task automatic release_bank();
        done = 1'b1;
        step("release_rise");
        done = 1'b0;
        step("release_low");
    endtask

    initial begin
        do_reset("reset");
        step("idle0");
        step("idle1");

        // Back-to-back 1..8.
        load_stream(1'b0, 1'b1, 8'd1);
        check("a_1to8", a_flat, 32'h04030201);
        check("b_1to8", b_flat, 32'h08070605);
        step("post_start");

        // A ninth element is refused and leaves the bank alone.
        in_valid = 1'b1;
        in_data  = 8'h99;
        step("ninth0");
        step("ninth1");
        in_valid = 1'b0;

        // Release, keep done high, reload 9..16: the sticky level must not re-arm.
        done = 1'b1;
        step("done_release");
        load_stream(1'b1, 1'b1, 8'd9);
        step("sticky0");
        step("sticky1");
        step("sticky2");
        check("a_9to16", a_flat, 32'h0c0b0a09);
        check("b_9to16", b_flat, 32'h100f0e0d);
        done = 1'b0;
        step("done_drop");
        done = 1'b1;
        step("done_edge");
        check("edge_ready", in_ready, 1'b1);
        done = 1'b0;
        step("done_low");

        // Reset in the middle of a load.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = DW'(8'h21 + i);
            step("partial");
        end
        in_valid = 1'b0;
        do_reset("mid_reset");
        step("after_reset");
        load_stream(1'b1, 1'b0, DW'($urandom));
        release_bank();

`ifdef MATLOAD_ABORT_EN
        // Abort on element 6 drops it; the next element is A[0].
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = DW'(8'h31 + i);
            step("pre_abort");
        end
        in_data = 8'h36;
        abort   = 1'b1;
        step("abort");
        abort   = 1'b0;
        in_valid = 1'b0;
        step("post_abort");
        load_stream(1'b0, 1'b1, 8'h41);
        abort = 1'b1;
        step("abort_in_full");
        abort = 1'b0;
        release_bank();
`endif

        // Further randomized loads.
        for (int r = 0; r < 3; r++) begin
            load_stream(1'b1, 1'b0, DW'($urandom));
            step("hold");
            release_bank();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
